// File: rtl/div_sequencer.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit: radix-2 restoring divider with
// a single-cycle fast path for divide-by-zero and signed overflow.
module div_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic            r_is_rem;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_div;
    logic [CW-1:0]   r_cnt;
    logic            r_done;
    logic [XLEN-1:0] r_result;

    logic            w_signed;
    logic            w_rs1_neg;
    logic            w_rs2_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_div0;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;
    logic            w_accept;
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN:0]   w_diff;
    logic            w_fits;
    logic [XLEN-1:0] w_rem_nx;
    logic [XLEN-1:0] w_quo_nx;
    logic            w_last;
    logic [XLEN-1:0] w_final;

    assign w_signed  = ~op[0];
    assign w_rs1_neg = w_signed & rs1[XLEN-1];
    assign w_rs2_neg = w_signed & rs2[XLEN-1];
    assign w_a_mag   = w_rs1_neg ? -rs1 : rs1;
    assign w_b_mag   = w_rs2_neg ? -rs2 : rs2;
    assign w_div0    = (rs2 == {XLEN{1'b0}});
    assign w_ovf     = w_signed && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == {XLEN{1'b1}});
    assign w_special = w_div0 | w_ovf;
    assign w_accept  = (r_state == S_IDLE) && start && !flush;

    // The shifted remainder can reach XLEN+1 bits; once it does, the borrow
    // bit of the trial subtraction is still a correct "fits" indicator.
    assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_div};
    assign w_fits   = ~w_diff[XLEN];
    assign w_rem_nx = w_fits ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
    assign w_quo_nx = {r_quo[XLEN-2:0], w_fits};
    assign w_last   = (r_cnt == CW'(XLEN - 1));

    // Fast-path result for divide-by-zero and signed overflow.
    always_comb begin
        w_special_res = {XLEN{1'b0}};
        if (w_div0) begin
            w_special_res = op[1] ? rs1 : {XLEN{1'b1}};
        end else begin
            w_special_res = op[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // Sign-corrected quotient or remainder from the final iteration.
    always_comb begin
        w_final = {XLEN{1'b0}};
        if (r_is_rem) begin
            w_final = r_neg_r ? -w_rem_nx : w_rem_nx;
        end else begin
            w_final = r_neg_q ? -w_quo_nx : w_quo_nx;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic; flush beats start in IDLE and aborts RUN.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && !flush) begin
                    w_state_nx = w_special ? S_DONE : S_RUN;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_RUN: begin
                if (flush) begin
                    w_state_nx = S_IDLE;
                end else if (w_last) begin
                    w_state_nx = S_DONE;
                end else begin
                    w_state_nx = S_RUN;
                end
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Busy decodes state only.
    always_comb begin
        busy = 1'b0;
        if (r_state != S_IDLE) begin
            busy = 1'b1;
        end else begin
            busy = 1'b0;
        end
    end

    // Operand load, restoring iteration and registered result/done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_rem    <= {XLEN{1'b0}};
            r_quo    <= {XLEN{1'b0}};
            r_div    <= {XLEN{1'b0}};
            r_cnt    <= {CW{1'b0}};
            r_done   <= 1'b0;
            r_result <= {XLEN{1'b0}};
        end else begin
            r_done <= (w_state_nx == S_DONE);
            if (w_accept) begin
                r_is_rem <= op[1];
                r_neg_q  <= w_rs1_neg ^ w_rs2_neg;
                r_neg_r  <= w_rs1_neg;
                r_rem    <= {XLEN{1'b0}};
                r_quo    <= w_a_mag;
                r_div    <= w_b_mag;
                r_cnt    <= {CW{1'b0}};
                if (w_special) begin
                    r_result <= w_special_res;
                end
            end else if ((r_state == S_RUN) && !flush) begin
                r_rem <= w_rem_nx;
                r_quo <= w_quo_nx;
                r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                if (w_last) begin
                    r_result <= w_final;
                end
            end
        end
    end

    assign done   = r_done;
    assign result = r_result;

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle controller and datapath for the RV32M divide/remainder instructions (DIV, DIVU, REM, REMU). It accepts one operation from the execute stage, runs a 32-iteration radix-2 restoring division and returns one registered result. It holds `busy` so pipeline control can stall the stage flops. It handles divide-by-zero and signed overflow in a fast path, and supports a synchronous flush from the hazard unit.

## Interface
Parameters:
- `XLEN`, 32: operand/result width; iteration count equals `XLEN`.

Ports:
- `clk`, in, 1: the single clock; all state updates on posedge.
- `reset`, in, 1: asynchronous, active-low; low forces the reset state immediately.
- `start`, in, 1: request; sampled only in IDLE.
- `op`, in, 2: 00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
- `rs1`, in, XLEN: dividend.
- `rs2`, in, XLEN: divisor.
- `flush`, in, 1: synchronous abort of any in-flight operation.
- `busy`, out, 1: high whenever state is not IDLE.
- `done`, out, 1: single-cycle pulse; `result` is valid.
- `result`, out, XLEN: quotient or remainder, registered; holds until the next `done`.

## Operation
States: IDLE, RUN, DONE.
- IDLE, `start`=1, `flush`=0: latch `op`, latch the sign flags, and load the operand magnitudes. Signed ops use the absolute value; unsigned ops use the raw value. Clear the iteration counter.
  - If `rs2`==0, or (`op`==DIV/REM, `rs1`==0x80000000 and `rs2`==0xFFFFFFFF): load the special result into `result` and go to DONE.
  - Otherwise go to RUN.
- RUN: one restoring iteration per cycle.
  - Shift {rem,quo} left by 1.
  - Trial-subtract the divisor in XLEN+1 bits; if non-negative, keep the difference and set quo[0].
  - Counter increments. On the XLEN-th iteration, register the sign-corrected selected value into `result` and go to DONE.
- DONE: `done`=1 for exactly this cycle, then go to IDLE.
- Sign correction:
  - Quotient is negated if DIV and sign(rs1)≠sign(rs2).
  - Remainder is negated if REM and rs1 is negative.
  - Unsigned ops are never negated.
- Special results:
  - Divide by zero: quotient 0xFFFFFFFF; remainder = `rs1` unmodified, for both signed and unsigned ops.
  - Overflow: quotient 0x80000000; remainder 0.
- `start` while `busy`: ignored; no queuing.
- `flush`:
  - In RUN or DONE: go to IDLE next edge, no `done`, and `result` is unchanged. A flush in the DONE cycle does not suppress that cycle's `done`.
  - In IDLE together with `start`: flush wins, so the start is dropped.
- Reset mid-operation: abort immediately; no `done` follows.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, counter 0, operand registers 0.
- Start accepted at edge E0 (cycle 0).
- Normal path:
  - RUN occupies cycles 1..32.
  - `done` is high in cycle 33, with `result` valid from cycle 33.
  - `busy` is high in cycles 1..33 and low in cycle 34.
  - Total latency 33 cycles; next start is accepted in cycle 34.
- Fast path: `done` and `result` in cycle 1; `busy` high in cycle 1 only.
- `busy` is combinational from state only, with no input-to-output paths. `done` and `result` are registered.
- Flush asserted in cycle k (1≤k≤32): `busy`=0 in cycle k+1, and a new start is accepted in cycle k+1.

## Test plan
- DIVU 100/7 -> `done` in cycle 33, `result`=14; REMU 100/7 -> 2; `busy` high cycles 1..33.
- Signed: DIV −7/2 -> 0xFFFFFFFD (−3); REM −7/2 -> 0xFFFFFFFF (−1); DIV 7/−2 -> 0xFFFFFFFD; REM 7/−2 -> 1.
- Divide by zero: DIV 5/0 -> 0xFFFFFFFF in cycle 1; REMU 0xDEADBEEF/0 -> 0xDEADBEEF in cycle 1.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in cycle 1; REM same operands -> 0. DIVU same operands takes the normal path -> 0 in cycle 33.
- Flush at cycle 10 -> no `done`, `busy`=0 in cycle 11, `result` keeps its old value. Then a new DIVU 9/3 started in cycle 11 -> 3 exactly 33 cycles later. Start while busy produces no extra `done`.
- `reset` low at cycle 15 of a run -> `busy`/`done`/`result` go to 0 immediately. After release, the first start behaves as from cold.
